// File: rtl/pll_pkg.sv
// Shared definitions for the VGA PLL bring-up logic: FSM state encoding,
// default timing for a 50 MHz reference clock, and a small sizing helper.
package pll_pkg;

    // Encodings are visible on the debug `state` port and must not change.
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Defaults for a 50 MHz refclk.
    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;   // 1 ms
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 4;
    localparam int unsigned DEF_CNT_W         = 8;

    // Largest of three values; used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for level signals crossing into clk.
// Resets to 0 so a downstream consumer sees "not asserted" until the
// source has been sampled twice after reset release.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture chain; first stage may go metastable.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source, which is what makes this a 2-deep chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// VGA PLL bring-up sequencer on the 50 MHz board clock. Holds the PLL in
// reset, waits for lock with a timeout and bounded retries, qualifies lock
// over a stability window and then raises `ready` for the pixel-domain
// reset. Lock loss or `reinit` restarts the sequence; saturating counters
// record timeouts and lock losses for debug.
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             reinit,
    output logic             pll_rst,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int unsigned PH_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned RT_W   = $clog2(MAX_RETRIES + 1);

    // Terminal phase values: the state is left on the edge that processes
    // the last cycle of its window, so each window lasts exactly N cycles.
    localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] TMO_LAST = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [PH_W-1:0] STB_LAST = PH_W'(STABLE_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_LIMIT = RT_W'(MAX_RETRIES);

    logic             lk_s;
    pll_state_e       state_q,       state_d;
    logic [PH_W-1:0]  phase_q,       phase_d;
    logic [RT_W-1:0]  retry_q,       retry_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q,    loss_cnt_d;
    logic             pll_rst_q,     pll_rst_d;
    logic             ready_q,       ready_d;
    logic             fault_q,       fault_d;

    // Debug counters stick at all-ones rather than wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // pll_locked comes from the PLL's own analogue loop, unrelated to refclk.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Next-state, counter and output-decode logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        timeout_cnt_d = timeout_cnt_q;
        loss_cnt_d    = loss_cnt_q;

        if (reinit) begin
            // Restart wins over every in-state event this cycle.
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (phase_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the terminal cycle still counts as lock.
                    if (lk_s) begin
                        state_d = ST_STABLE;
                    end else if (phase_q == TMO_LAST) begin
                        timeout_cnt_d = sat_inc(timeout_cnt_q);
                        retry_d       = retry_q + 1'b1;
                        state_d       = (retry_d == RT_LIMIT) ? ST_FAULT : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!lk_s) begin
                        loss_cnt_d = sat_inc(loss_cnt_q);
                        state_d    = ST_RESET;
                    end else if (phase_q == STB_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        loss_cnt_d = sat_inc(loss_cnt_q);
                        state_d    = ST_RESET;
                    end
                end
                ST_FAULT: begin
                    // Parked with the PLL held in reset until reinit.
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end

        // Phase restarts on every entry (a reinit in RESET re-enters RESET).
        // It only advances in the timed states, so it cannot wrap while
        // parked in RUN or FAULT.
        if (reinit || (state_d != state_q)) begin
            phase_d = '0;
        end else if ((state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            phase_d = phase_q + 1'b1;
        end else begin
            phase_d = phase_q;
        end

        // Outputs decode the next state so they flip on the same edge as it.
        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    // State, counter and registered-output flops. pll_rst resets high so the
    // PLL is held in reset the instant rst_n falls, without waiting for a clock.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            phase_q       <= '0;
            retry_q       <= '0;
            timeout_cnt_q <= '0;
            loss_cnt_q    <= '0;
            pll_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            retry_q       <= retry_d;
            timeout_cnt_q <= timeout_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            pll_rst_q     <= pll_rst_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign state       = state_q;
    assign pll_rst     = pll_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign timeout_cnt = timeout_cnt_q;
    assign loss_cnt    = loss_cnt_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sits on the free-running 50 MHz board clock beside the VGA PLL. It drives the PLL's active-high reset and watches the PLL lock indication. It qualifies lock with a stability window, retries on lock timeout and re-initialises on lock loss. It produces a single `ready` qualifier that gates the pixel-domain reset, plus saturating fault counters for debug readout.

Parameters:
- RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed for lock after pll_rst release (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before ready.
- MAX_RETRIES, 4: consecutive timeouts before entering FAULT (>=1).
- CNT_W, 8: width of debug counters.

Ports:
- refclk, in, 1: 50 MHz reference clock; never the PLL output.
- rst_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL lock indication, asynchronous to refclk.
- reinit, in, 1: single-cycle request to restart the sequence from any state.
- pll_rst, out, 1: active-high reset to the PLL.
- ready, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- state, out, 3: encoded FSM state (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4).
- timeout_cnt, out, CNT_W: cumulative lock timeouts, saturating.
- loss_cnt, out, CNT_W: cumulative lock losses in STABLE or RUN, saturating.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low, ports named refclk / rst_n.
- Reset values while rst_n=0:
  - state=RESET, pll_rst=1, ready=0, fault=0.
  - timeout_cnt=0, loss_cnt=0, retry counter=0, phase counter=0.
  - Synchroniser flops=0.
- pll_locked passes through a 2-flop synchroniser (lk_s). The FSM uses only lk_s.
- All outputs are registered. pll_rst, ready and fault are decoded from the next state, so they change on the same edge as state.
- One shared phase counter, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). It is cleared on every state entry.
- RESET:
  - pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0.
  - lk_s=1: go to STABLE.
  - After LOCK_TIMEOUT cycles without lock: timeout_cnt+=1 (saturating) and retry+=1.
  - If retry then equals MAX_RETRIES, go to FAULT; otherwise go to RESET.
- STABLE:
  - lk_s=0: loss_cnt+=1, go to RESET.
  - STABLE_CYCLES consecutive cycles with lk_s=1: go to RUN and clear retry.
- RUN:
  - ready=1.
  - lk_s=0: loss_cnt+=1, go to RESET. ready falls on that same edge, i.e. at most 3 refclk edges after pll_locked falls.
- FAULT:
  - pll_rst=1, fault=1. Stays until reinit.
- reinit=1 in any state (FAULT included): go to RESET and clear retry; debug counters are kept.
  - Takes priority over timeout, lock loss and stable completion in the same cycle.
- Same cycle as the timeout terminal count with lk_s=1: lock wins, go to STABLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- rst_n asserted mid-sequence: immediate async return to reset values, with pll_rst high combinationally via the reset path.

Decomposition:
- Shared package (pll_pkg):
  - State enum/localparams, with encodings as listed.
  - Default timing constants for 50 MHz.
- Sub-module sync_2ff:
  - Generic 2-flop synchroniser with async active-low reset and reset value 0.
  - Reused later for the pixel-domain reset release.

Test Plan:
(all with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3)
- Nominal bring-up: pll_locked rises 5 cycles after pll_rst falls and stays high.
  - pll_rst high exactly 4 cycles after rst_n release.
  - ready rises 2 (sync) + 1 + 8 cycles after lock; timeout_cnt=0, loss_cnt=0.
- Timeout/retry: pll_locked held 0.
  - Three RESET/WAIT_LOCK cycles of 4+20.
  - timeout_cnt steps 1, 2, 3; then FAULT with fault=1 and pll_rst=1 held.
  - reinit pulse -> RESET, fault=0, timeout_cnt stays 3.
- Lock glitch in STABLE: pll_locked drops for 3 cycles after 5 stable cycles.
  - loss_cnt=1, pll_rst high for 4 cycles, ready never asserted before a full 8-cycle window.
- Lock loss in RUN: pll_locked falls.
  - ready=0 within 3 edges, loss_cnt increments, sequence re-runs to ready.
- Priority: reinit asserted in the same cycle as the timeout terminal count.
  - RESET entered, timeout_cnt unchanged.
  - Also: lock and timeout in the same cycle -> STABLE.
- Async reset mid-RUN plus saturation:
  - rst_n low for 1 ns yields all reset values immediately.
  - Forcing 300 lock losses with CNT_W=8 holds loss_cnt at 255.
